// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline controller. Merges stall requests, sequences EX branch
// redirects around outstanding fetches, and keeps saturating stall/flush counters.
`default_nettype none

module pipe_ctrl #(
  parameter int CNT_W     = 32,
  parameter int DRAIN_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_tgt_i,
  input  logic             if_busy_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic             discard_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             drain_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int            DW         = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     tgt_q;
  logic [DW-1:0]   drain_cnt;
  logic [5:0]      merged;
  logic            accept;
  logic            drain_timeout;

  // Highest stalled stage freezes itself and everything upstream of it.
  always_comb begin
    merged = 6'b000000;
    if (stallreq_mem_i)     merged = 6'b011111;
    else if (stallreq_ex_i) merged = 6'b001111;
    else if (stallreq_id_i) merged = 6'b000111;
    else if (stallreq_if_i) merged = 6'b000011;
  end

  assign accept = branch_flag_i & ~stallreq_mem_i & ~stallreq_ex_i & (state == RUN);

  always_comb begin
    state_nxt     = state;
    stall_o       = merged;
    flush_o       = 1'b0;
    discard_o     = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    drain_timeout = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          flush_o = 1'b1;
          if (if_busy_i) begin
            discard_o = 1'b1;
            state_nxt = DRAIN;
          end else begin
            redirect_o    = 1'b1;
            redirect_pc_o = branch_tgt_i;
          end
        end
      end
      DRAIN: begin
        // Hold the PC and bubble IF/ID until the wrong-path fetch has returned.
        stall_o   = merged | 6'b000011;
        discard_o = 1'b1;
        if (!if_busy_i) begin
          discard_o     = 1'b0;
          redirect_o    = 1'b1;
          redirect_pc_o = tgt_q;
          state_nxt     = RUN;
        end else if (drain_cnt == DRAIN_LAST) begin
          drain_timeout = 1'b1;
          redirect_o    = 1'b1;
          redirect_pc_o = tgt_q;
          state_nxt     = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      tgt_q       <= 32'h0;
      drain_cnt   <= '0;
      drain_err_o <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept && if_busy_i) begin
        tgt_q     <= branch_tgt_i;
        drain_cnt <= '0;
      end else if (state == DRAIN && if_busy_i && !drain_timeout) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
      if (drain_timeout) drain_err_o <= 1'b1;
      if ((stall_o != 6'b000000) && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (accept && (flush_cnt_o != {CNT_W{1'b1}}))
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (8-bit counters, DRAIN_MAX=15).
`default_nettype none

module tb_pipe_ctrl;

  localparam int CNT_W     = 8;
  localparam int DRAIN_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic             branch_flag;
  logic [31:0]      branch_tgt;
  logic             if_busy;
  logic [5:0]       stall;
  logic             flush, discard, redirect, drain_err;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stallreq_if_i (stallreq_if),
    .stallreq_id_i (stallreq_id),
    .stallreq_ex_i (stallreq_ex),
    .stallreq_mem_i(stallreq_mem),
    .branch_flag_i (branch_flag),
    .branch_tgt_i  (branch_tgt),
    .if_busy_i     (if_busy),
    .stall_o       (stall),
    .flush_o       (flush),
    .discard_o     (discard),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .drain_err_o   (drain_err),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a falling edge, then sample outputs 1ns later.
  task automatic drive(input logic s_if, input logic s_id, input logic s_ex, input logic s_mem,
                       input logic br, input logic [31:0] tgt, input logic busy);
    @(negedge clk);
    stallreq_if  = s_if;
    stallreq_id  = s_id;
    stallreq_ex  = s_ex;
    stallreq_mem = s_mem;
    branch_flag  = br;
    branch_tgt   = tgt;
    if_busy      = busy;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic [5:0] e_stall, input logic e_flush,
                          input logic e_discard, input logic e_redir, input logic [31:0] e_pc);
    chk({tag, ".stall"},    64'(stall),       64'(e_stall));
    chk({tag, ".flush"},    64'(flush),       64'(e_flush));
    chk({tag, ".discard"},  64'(discard),     64'(e_discard));
    chk({tag, ".redirect"}, 64'(redirect),    64'(e_redir));
    chk({tag, ".pc"},       64'(redirect_pc), 64'(e_pc));
  endtask

  initial begin
    rst_n = 1'b0;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    branch_flag = 0; branch_tgt = 32'h0; if_busy = 0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk_comb("reset", 6'b000000, 0, 0, 0, 32'h0);
    chk("reset.err", 64'(drain_err), 64'd0);
    chk("reset.scnt", 64'(stall_cnt), 64'd0);
    chk("reset.fcnt", 64'(flush_cnt), 64'd0);
    rst_n = 1'b1;

    // Stall merge priorities and per-cycle stall counting
    drive(0, 1, 0, 1, 0, 32'h0, 0);
    chk("idmem.stall", 64'(stall), 64'b011111);
    chk("idmem.scnt0", 64'(stall_cnt), 64'd0);
    drive(0, 1, 0, 1, 0, 32'h0, 0);
    chk("idmem.scnt1", 64'(stall_cnt), 64'd1);
    drive(0, 1, 0, 1, 0, 32'h0, 0);
    chk("idmem.scnt2", 64'(stall_cnt), 64'd2);
    drive(1, 1, 1, 0, 0, 32'h0, 0);
    chk("ex.stall", 64'(stall), 64'b001111);
    chk("ex.scnt", 64'(stall_cnt), 64'd3);
    drive(1, 1, 0, 0, 0, 32'h0, 0);
    chk("id.stall", 64'(stall), 64'b000111);
    drive(1, 0, 0, 0, 0, 32'h0, 0);
    chk("if.stall", 64'(stall), 64'b000011);
    chk("if.scnt", 64'(stall_cnt), 64'd5);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("idle.stall", 64'(stall), 64'b000000);
    chk("idle.scnt", 64'(stall_cnt), 64'd6);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("idle2.scnt", 64'(stall_cnt), 64'd6);

    // Immediate redirect, fetch port idle
    drive(0, 0, 0, 0, 1, 32'h100, 0);
    chk_comb("br100", 6'b000000, 1, 0, 1, 32'h100);
    chk("br100.fcnt0", 64'(flush_cnt), 64'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk_comb("br100.after", 6'b000000, 0, 0, 0, 32'h0);
    chk("br100.fcnt1", 64'(flush_cnt), 64'd1);

    // Branch while a fetch is outstanding: DRAIN for 3 busy cycles, then redirect
    drive(0, 0, 0, 0, 1, 32'h200, 1);
    chk_comb("br200.acc", 6'b000000, 1, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    chk_comb("br200.d1", 6'b000011, 0, 1, 0, 32'h0);
    chk("br200.fcnt", 64'(flush_cnt), 64'd2);
    chk("br200.scnt6", 64'(stall_cnt), 64'd6);
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    chk_comb("br200.d2", 6'b000011, 0, 1, 0, 32'h0);
    drive(0, 0, 0, 0, 1, 32'h999, 1);
    chk_comb("br200.d3ign", 6'b000011, 0, 1, 0, 32'h0);
    chk("br200.scnt8", 64'(stall_cnt), 64'd8);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk_comb("br200.exit", 6'b000011, 0, 0, 1, 32'h200);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk_comb("br200.run", 6'b000000, 0, 0, 0, 32'h0);
    chk("br200.scnt10", 64'(stall_cnt), 64'd10);
    chk("br200.fcnt2", 64'(flush_cnt), 64'd2);

    // Branch held under MEM stall is accepted once on release
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 32'h300, 0);
      chk_comb($sformatf("held%0d", i), 6'b011111, 0, 0, 0, 32'h0);
      chk($sformatf("held%0d.scnt", i), 64'(stall_cnt), 64'(10 + i));
    end
    drive(0, 0, 0, 0, 1, 32'h300, 0);
    chk_comb("held.rel", 6'b000000, 1, 0, 1, 32'h300);
    chk("held.fcnt2", 64'(flush_cnt), 64'd2);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("held.fcnt3", 64'(flush_cnt), 64'd3);
    chk("held.scnt14", 64'(stall_cnt), 64'd14);

    // Asynchronous reset in the middle of DRAIN
    drive(0, 0, 0, 0, 1, 32'h400, 1);
    chk("rd.acc.flush", 64'(flush), 64'd1);
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    chk("rd.drain.stall", 64'(stall), 64'b000011);
    rst_n = 1'b0;
    #1;
    chk_comb("rd.inrst", 6'b000000, 0, 0, 0, 32'h0);
    chk("rd.inrst.scnt", 64'(stall_cnt), 64'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    rst_n = 1'b1;
    #1;
    chk_comb("rd.post", 6'b000000, 0, 0, 0, 32'h0);
    chk("rd.post.scnt", 64'(stall_cnt), 64'd0);
    chk("rd.post.fcnt", 64'(flush_cnt), 64'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("rd.post2.stall", 64'(stall), 64'b000000);

    // Stuck fetch: forced redirect on the DRAIN_MAX-th DRAIN cycle, sticky error
    drive(0, 0, 0, 0, 1, 32'h500, 1);
    chk_comb("to.acc", 6'b000000, 1, 1, 0, 32'h0);
    for (int i = 1; i < DRAIN_MAX; i++) begin
      drive(0, 0, 0, 0, 0, 32'h0, 1);
      chk($sformatf("to.d%0d.redir", i), 64'(redirect), 64'd0);
      chk($sformatf("to.d%0d.discard", i), 64'(discard), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 32'h0, 1);
    chk_comb("to.force", 6'b000011, 0, 1, 1, 32'h500);
    chk("to.force.err", 64'(drain_err), 64'd0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk_comb("to.run", 6'b000000, 0, 0, 0, 32'h0);
    chk("to.err1", 64'(drain_err), 64'd1);
    chk("to.scnt", 64'(stall_cnt), 64'(DRAIN_MAX));
    chk("to.fcnt", 64'(flush_cnt), 64'd1);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("to.err.sticky", 64'(drain_err), 64'd1);

    // Counter saturation
    for (int i = 0; i < 300; i++) drive(1, 0, 0, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("sat.scnt", 64'(stall_cnt), 64'hFF);
    for (int i = 0; i < 260; i++) drive(0, 0, 0, 0, 1, 32'h600, 0);
    drive(0, 0, 0, 0, 0, 32'h0, 0);
    chk("sat.fcnt", 64'(flush_cnt), 64'hFF);
    chk("sat.scnt.hold", 64'(stall_cnt), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
